// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised multi-pin GPIO controller.
//
// Each input pin goes through a SYNC_STAGES-deep synchroniser, then an
// optional debounce filter, then a per-pin edge detector. Detected edges
// are captured in a sticky, maskable, write-1-to-clear status register.
// A single interrupt line is the OR of the status bits.
//
// Build option: define GPIO_CTRL_DEBOUNCE_EN to build the debounce filter.
// Without it the filtered value simply follows the synchroniser output
// one edge later, and DEBOUNCE_CYCLES is ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   gpio_in             raw asynchronous pin inputs
//   gpio_out, gpio_oe   registered output data / output enable (1 = drive)
//   out_wr, out_wdata   load gpio_out
//   oe_wr, oe_wdata     load gpio_oe
//   pin_val             synchronised and filtered input value
//   irq_rise_en/fall_en per-pin edge capture enables
//   irq_clr             write-1-to-clear pulse for irq_status
//   irq_status, irq     sticky per-pin edge status and its OR-reduction
module gpio_ctrl #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic             out_wr,
  input  logic [WIDTH-1:0] out_wdata,
  input  logic             oe_wr,
  input  logic [WIDTH-1:0] oe_wdata,
  output logic [WIDTH-1:0] pin_val,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;      // synchroniser output
  logic [WIDTH-1:0] nxt;    // value pin_val takes on this edge
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Unsupported parameter combinations leave this empty block elaborated,
  // making a bad configuration visible in the hierarchy.
  if (WIDTH < 1 || WIDTH > 64 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_unsupported_params
  end

  // Output data and output-enable registers, independently written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= RESET_OUT;
      gpio_oe  <= '0;
    end else begin
      if (out_wr) begin
        gpio_out <= out_wdata;
      end
      if (oe_wr) begin
        gpio_oe <= oe_wdata;
      end
    end
  end

  // Input synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Debounce decision: a pin only changes after the synchroniser has
  // disagreed with it for DEBOUNCE_CYCLES consecutive edges; any agreeing
  // cycle restarts the count, so the counter can never wrap.
  always_comb begin
    nxt = pin_val;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] == pin_val[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        nxt[i]   = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end
`else
  assign nxt = s;
`endif

  // Edges are judged on the value being loaded this edge, so status rises
  // on the same edge as pin_val.
  assign rise = nxt & ~pin_val & irq_rise_en;
  assign fall = ~nxt & pin_val & irq_fall_en;

  // Filtered pin value and sticky status; a new event beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_val    <= '0;
      irq_status <= '0;
    end else begin
      pin_val    <= nxt;
      irq_status <= (irq_status & ~irq_clr) | rise | fall;
    end
  end

  // Driven only from status flops, so it cannot glitch.
  assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed testbench for gpio_ctrl (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_OUT=0). Expected input latency and glitch
// behaviour follow the GPIO_CTRL_DEBOUNCE_EN build option.
module tb_gpio_ctrl;

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int LAT = 6;
  localparam logic [7:0] GLITCH_MASK = 8'h00;
  localparam logic [7:0] GLITCH_STATUS = 8'h00;
`else
  localparam int LAT = 3;
  localparam logic [7:0] GLITCH_MASK = 8'h1C;
  localparam logic [7:0] GLITCH_STATUS = 8'h01;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       out_wr;
  logic [7:0] out_wdata;
  logic       oe_wr;
  logic [7:0] oe_wdata;
  logic [7:0] pin_val;
  logic [7:0] irq_rise_en;
  logic [7:0] irq_fall_en;
  logic [7:0] irq_clr;
  logic [7:0] irq_status;
  logic       irq;

  int checks = 0;
  int errors = 0;

  gpio_ctrl #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RESET_OUT(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .out_wr(out_wr),
    .out_wdata(out_wdata),
    .oe_wr(oe_wr),
    .oe_wdata(oe_wdata),
    .pin_val(pin_val),
    .irq_rise_en(irq_rise_en),
    .irq_fall_en(irq_fall_en),
    .irq_clr(irq_clr),
    .irq_status(irq_status),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns just after the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] mask;

  initial begin
    rst = 1'b1;
    gpio_in = 8'hFF;
    out_wr = 1'b0; out_wdata = 8'h00;
    oe_wr = 1'b0;  oe_wdata = 8'h00;
    irq_rise_en = 8'h00; irq_fall_en = 8'h00; irq_clr = 8'h00;

    // Reset state with all pins high.
    step(3);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_gpio_oe", gpio_oe, 8'h00);
    check("rst_pin_val", pin_val, 8'h00);
    check("rst_status", irq_status, 8'h00);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    step(LAT - 1);
    check("rel_pin_val_early", pin_val, 8'h00);
    step(1);
    check("rel_pin_val", pin_val, 8'hFF);
    check("rel_status", irq_status, 8'h00);
    check("rel_irq", irq, 1'b0);

    // Rising edge on pin 3 with capture enabled, then clear.
    gpio_in = 8'hF7;
    step(LAT + 2);
    check("p3_low", pin_val, 8'hF7);
    irq_rise_en = 8'h08;
    gpio_in = 8'hFF;
    step(LAT - 1);
    check("p3_rise_early_pin", pin_val, 8'hF7);
    check("p3_rise_early_status", irq_status, 8'h00);
    step(1);
    check("p3_rise_pin", pin_val, 8'hFF);
    check("p3_rise_status", irq_status, 8'h08);
    check("p3_rise_irq", irq, 1'b1);
    irq_clr = 8'h08;
    step(1);
    irq_clr = 8'h00;
    check("p3_clr_status", irq_status, 8'h00);
    check("p3_clr_irq", irq, 1'b0);

    // Three-cycle glitch on pin 0.
    gpio_in = 8'hFE;
    step(LAT + 2);
    check("p0_low", pin_val, 8'hFE);
    irq_rise_en = 8'h01;
    gpio_in = 8'hFF;
    mask = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) gpio_in = 8'hFE;
      mask[k] = pin_val[0];
    end
    check("glitch_pin_trace", mask, GLITCH_MASK);
    check("glitch_status", irq_status, GLITCH_STATUS);
    irq_clr = 8'hFF;
    step(1);
    irq_clr = 8'h00;
    check("glitch_clr", irq_status, 8'h00);

    // Collision: clear and a new falling edge on pin 5 on the same edge.
    irq_rise_en = 8'h00;
    irq_fall_en = 8'h20;
    gpio_in = 8'hDE;
    step(LAT);
    check("p5_fall_status", irq_status, 8'h20);
    gpio_in = 8'hFE;
    step(LAT + 2);
    check("p5_high_again", pin_val, 8'hFE);
    check("p5_hold_status", irq_status, 8'h20);
    gpio_in = 8'hDE;
    step(LAT - 1);
    check("p5_pre_fall_pin", pin_val, 8'hFE);
    irq_clr = 8'h20;
    step(1);
    irq_clr = 8'h00;
    check("coll_pin", pin_val, 8'hDE);
    check("coll_status", irq_status, 8'h20);
    step(1);
    check("coll_status_hold", irq_status, 8'h20);
    irq_fall_en = 8'h00;
    step(1);
    check("en_off_keeps_status", irq_status, 8'h20);

    // Output writes, together then data alone.
    out_wr = 1'b1; out_wdata = 8'hA5;
    oe_wr = 1'b1;  oe_wdata = 8'h0F;
    step(1);
    out_wr = 1'b0; out_wdata = 8'h00;
    oe_wr = 1'b0;  oe_wdata = 8'hFF;
    check("wr_gpio_out", gpio_out, 8'hA5);
    check("wr_gpio_oe", gpio_oe, 8'h0F);
    step(10);
    check("hold_gpio_out", gpio_out, 8'hA5);
    check("hold_gpio_oe", gpio_oe, 8'h0F);
    out_wr = 1'b1; out_wdata = 8'h3C;
    step(1);
    out_wr = 1'b0;
    check("wr2_gpio_out", gpio_out, 8'h3C);
    check("wr2_gpio_oe", gpio_oe, 8'h0F);

    // Asynchronous reset pulse while pin 2 is mid-debounce.
    gpio_in = 8'hDA;
    step(4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pin_val", pin_val, 8'h00);
    check("arst_status", irq_status, 8'h00);
    check("arst_irq", irq, 1'b0);
    check("arst_gpio_out", gpio_out, 8'h00);
    check("arst_gpio_oe", gpio_oe, 8'h00);
    #4;
    rst = 1'b0;
    @(negedge clk);
    step(LAT - 1);
    check("arst_relat_early", pin_val, 8'h00);
    step(1);
    check("arst_relat", pin_val, 8'hDA);
    check("arst_rel_status", irq_status, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised multi-pin GPIO controller that the GPIO UVC drives and monitors at block level. It registers per-pin output data and output-enable values. Each input pin passes through a synchroniser and a debounce filter, then a per-pin edge detector. Edge events are captured into a sticky, maskable interrupt status with a single aggregated interrupt line.

## Interface
- WIDTH, 8: number of GPIO pins (1..64).
- SYNC_STAGES, 2: input synchroniser depth (2..4).
- DEBOUNCE_CYCLES, 4: number of consecutive stable cycles required before a filtered input changes (1..65535).
- RESET_OUT, '0: reset value of `gpio_out` (WIDTH bits).

Ports:
- clk  in  1  single clock; all state is on posedge.
- rst  in  1  asynchronous, active-high reset.
- gpio_in  in  WIDTH  raw, asynchronous pin inputs.
- gpio_out  out  WIDTH  registered output data.
- gpio_oe  out  WIDTH  registered output enable; 1 = drive.
- out_wr  in  1  load `gpio_out` from `out_wdata`.
- out_wdata  in  WIDTH  output data to load.
- oe_wr  in  1  load `gpio_oe` from `oe_wdata`.
- oe_wdata  in  WIDTH  output-enable value to load.
- pin_val  out  WIDTH  synchronised and filtered input value.
- irq_rise_en  in  WIDTH  per-pin rising-edge capture enable.
- irq_fall_en  in  WIDTH  per-pin falling-edge capture enable.
- irq_clr  in  WIDTH  write-1-to-clear pulse for `irq_status`.
- irq_status  out  WIDTH  sticky per-pin edge status.
- irq  out  1  OR-reduction of `irq_status`.

## Operation
- Reset values: `gpio_out`=RESET_OUT, `gpio_oe`=0, `pin_val`=0, `irq_status`=0, `irq`=0. Synchroniser flops and debounce counters are also 0.
- Output path: when `out_wr` is 1, `gpio_out` takes `out_wdata` on the next edge. `oe_wr` loads `gpio_oe` the same way. The two writes are independent and may occur together. Registers hold when their write strobe is not asserted.
- Synchroniser: a SYNC_STAGES-deep flop chain per pin. Its output is `s[i]`.
- Debounce, per pin, with a counter of $clog2(DEBOUNCE_CYCLES+1) bits:
  - If `s[i]`==`pin_val[i]`, the counter is set to 0.
  - Otherwise, if counter==DEBOUNCE_CYCLES-1, `pin_val[i]` <= `s[i]` and the counter is set to 0.
  - Otherwise, the counter increments.
  - Any cycle where `s[i]` returns to `pin_val[i]` restarts the count. The counter never wraps.
- Edge detect uses `nxt` (the value `pin_val` takes this edge):
  - rise[i] = `nxt[i]` & ~`pin_val[i]` & `irq_rise_en[i]`.
  - fall[i] = ~`nxt[i]` & `pin_val[i]` & `irq_fall_en[i]`.
- Status update: `irq_status` <= (`irq_status` & ~`irq_clr`) | rise | fall. A set on the same edge as a clear wins, so no event is lost.
- Enables gate capture only. Clearing an enable does not clear an existing status bit.
- `irq` is derived combinationally from `irq_status` flops only, so it is glitch-free.
- Pins high at reset release produce a rising edge on `pin_val` after the input latency. That edge is captured only if `irq_rise_en` is already set.

## Timing
- Input latency: a stable change on `gpio_in[i]` reaches `pin_val[i]` exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after first being sampled.
- `irq_status` and `irq` assert on the same edge that `pin_val` changes.
- `irq_clr` takes effect on the next edge. `irq` drops on that edge if no other bits are set.
- Output write latency: 1 edge.
- Reset asserted mid-operation forces all outputs to reset values immediately, without waiting for a clock edge. Partial debounce counts are discarded. After release, counting restarts from 0.

## Configuration
- `GPIO_CTRL_DEBOUNCE_EN` defined: the debounce filter is built as described above.
- Not defined:
  - No counters are instantiated and DEBOUNCE_CYCLES is ignored.
  - `pin_val` <= `s` every edge.
  - Input latency is SYNC_STAGES+1 edges, and glitches of one or more cycles propagate.

## Test plan
Parameters for all scenarios: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_OUT=8'h00, macro defined unless stated.
- Reset with `gpio_in`=8'hFF, all enables 0: `gpio_out`=00, `gpio_oe`=00, `pin_val`=00 during reset. After release, `pin_val` becomes FF after 6 edges, `irq_status` stays 00, `irq`=0.
- `irq_rise_en`=8'h08, `gpio_in[3]` goes 0→1 and is held: `pin_val[3]` rises on the 6th edge, with `irq_status`=8'h08 and `irq`=1 on the same edge. `irq_clr`=8'h08 for one cycle gives `irq_status`=00 and `irq`=0 on the next edge.
- Glitch: `gpio_in[0]` high for 3 cycles, then low: `pin_val[0]` stays 0 and no status is set. Repeated with the macro undefined: `pin_val[0]` pulses high for 3 cycles.
- Collision: `irq_status[5]`=1 and `irq_fall_en[5]`=1, with `irq_clr`=8'h20 on the same edge a debounced falling edge lands on pin 5: `irq_status[5]` remains 1.
- Outputs: `out_wr`=1 with `out_wdata`=8'hA5 and `oe_wr`=1 with `oe_wdata`=8'h0F in the same cycle: next edge `gpio_out`=A5, `gpio_oe`=0F. Both values hold over 10 idle cycles.
- `rst` pulsed for half a clock while pin 2's debounce count is at 2: `pin_val`, `irq_status` and `gpio_out` go to reset values immediately. A held input then takes the full 6 edges again after release.
